// File: rtl/fir_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared types and helpers for the FIR coefficient controller.
//   ctrl_state_t : controller FSM states
//   SETTLE_MULT  : settle window length, in multiples of N_TAPS cycles
//   load_len()   : number of beats expected for one complete load
// Build option: FIR_COEF_SYM_EN selects linear-phase (half-length) loads.
// ---------------------------------------------------------------------------
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        COMMIT = 3'd3,
        SETTLE = 3'd4
    } ctrl_state_t;

    localparam int SETTLE_MULT = 2;

    // A symmetric load carries taps 0..ceil(N/2)-1; the rest are mirrored.
    function automatic int load_len(input int n_taps);
`ifdef FIR_COEF_SYM_EN
        return (n_taps + 1) / 2;
`else
        return n_taps;
`endif
    endfunction

endpackage

// File: rtl/fir_settle_timer.sv
// ---------------------------------------------------------------------------
// fir_settle_timer
// Loadable down-counter that owns the coefficient-stable flag.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val into the counter and drop stable
//   load_val  : reload value (window length minus one)
//   count     : decrement enable; at zero, stable is raised instead
//   done      : counter is zero
//   stable    : registered coefficient-stable flag
// ---------------------------------------------------------------------------
module fir_settle_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             done,
    output logic             stable
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (load) begin
            cnt_d    = load_val;
            stable_d = 1'b0;
        end else if (count) begin
            // The zero cycle is the last cycle of the window: stable rises
            // on its closing edge rather than wrapping the counter.
            if (cnt_q == '0) begin
                stable_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign done   = (cnt_q == '0);
    assign stable = stable_q;

endmodule

// File: rtl/fir_coef_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coef_ctrl
// Loads a coefficient stream into a shadow bank, checks its length, commits
// it atomically to the active bank driving the FIR taps, then holds
// coef_stable low for SETTLE_MULT*N_TAPS cycles while the pipeline flushes.
//
// Handshake: a beat transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is decoded from the state register only (no path from
// cfg_valid); it is high in IDLE, LOAD and DRAIN. The source must hold
// cfg_data/cfg_last stable while cfg_valid is high and cfg_ready is low.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_valid   : beat valid          cfg_ready : beat can be accepted
//   cfg_data    : coefficient, tap 0 first
//   cfg_last    : final beat of a load
//   coef_flat   : active bank, tap k at [k*COEF_WIDTH +: COEF_WIDTH]
//   coef_swap   : one-cycle pulse, first cycle the new bank is visible
//   coef_stable : filter output reflects only the active bank
//   err_len     : one-cycle pulse on a short or long load
//   busy        : state is not IDLE
//   state_dbg   : current FSM state
// Build option: FIR_COEF_SYM_EN enables linear-phase (mirrored) loads.
// ---------------------------------------------------------------------------
module fir_coef_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int N_TAPS     = 16,
    parameter int COEF_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic signed [COEF_WIDTH-1:0]   cfg_data,
    input  logic                           cfg_last,
    output logic [N_TAPS*COEF_WIDTH-1:0]   coef_flat,
    output logic                           coef_swap,
    output logic                           coef_stable,
    output logic                           err_len,
    output logic                           busy,
    output ctrl_state_t                    state_dbg
);

    localparam int IDX_W      = $clog2(N_TAPS) + 1;
    localparam int SETTLE_CYC = SETTLE_MULT * N_TAPS;
    localparam int CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int LEN        = load_len(N_TAPS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LEN - 1);
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC - 1);

    ctrl_state_t                    state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [COEF_WIDTH-1:0]          shadow_q [N_TAPS];
    logic [COEF_WIDTH-1:0]          shadow_d [N_TAPS];
    logic [N_TAPS*COEF_WIDTH-1:0]   flat_q, flat_d;
    logic                           swap_q, swap_d;
    logic                           err_q, err_d;

    logic                           accept;
    logic                           wr_en;
    logic [IDX_W-1:0]               wr_idx;
    logic                           timer_done;
    logic                           timer_stable;

    assign cfg_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN);
    assign accept    = cfg_valid && cfg_ready;

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        swap_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    idx_d  = IDX_W'(1);
                    if (cfg_last) begin
                        if (LAST_IDX == '0) begin
                            state_d = COMMIT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (LAST_IDX == '0) begin
                        // Single-beat bank and the source keeps going:
                        // treat as a long load right away.
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = idx_q;
                    if (cfg_last) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                        idx_d = '0;
                    end else if (idx_q == LAST_IDX) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && cfg_last) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                swap_d  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (timer_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow bank writes. A partially written shadow bank is harmless since
    // only a complete load ever reaches COMMIT.
    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            shadow_d[k] = shadow_q[k];
            if (wr_en && (IDX_W'(k) == wr_idx)) begin
                shadow_d[k] = cfg_data;
            end
`ifdef FIR_COEF_SYM_EN
            // Mirror beat j into tap N_TAPS-1-j.
            if (wr_en && (IDX_W'(N_TAPS - 1 - k) == wr_idx)) begin
                shadow_d[k] = cfg_data;
            end
`endif
        end
    end

    // Active bank only changes in COMMIT.
    always_comb begin
        flat_d = flat_q;
        if (state_q == COMMIT) begin
            for (int k = 0; k < N_TAPS; k++) begin
                flat_d[k*COEF_WIDTH +: COEF_WIDTH] = shadow_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            flat_q  <= '0;
            swap_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flat_q  <= flat_d;
            swap_q  <= swap_d;
            err_q   <= err_d;
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    // Loaded on the COMMIT edge, so stable drops in the same cycle the new
    // bank and coef_swap appear, and rises SETTLE_CYC cycles later.
    fir_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == COMMIT),
        .load_val (SETTLE_VAL),
        .count    (state_q == SETTLE),
        .done     (timer_done),
        .stable   (timer_stable)
    );

    assign coef_flat   = flat_q;
    assign coef_swap   = swap_q;
    assign coef_stable = timer_stable;
    assign err_len     = err_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule
